// File: rtl/bullet_scheduler_pkg.sv
// Shared game constants for the bullet scheduler and its slots.
// Position width, screen size and facing-direction encoding.
package bullet_scheduler_pkg;

  localparam int   POS_W     = 10;
  localparam int   SCREEN_W  = 800;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: holds valid/x/y/dir; spawn load, tick step, retire.
// Ports: spawn_i/_x_i/_y_i/_dir_i load, tick_i step, hit_i wall hit.
module bullet_slot #(
  parameter int SCREEN_W = bullet_scheduler_pkg::SCREEN_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spawn_i,
  input  logic [9:0] spawn_x_i,
  input  logic [9:0] spawn_y_i,
  input  logic       spawn_dir_i,
  input  logic       tick_i,
  input  logic       hit_i,
  output logic       valid_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       dir_o
);
  import bullet_scheduler_pkg::*;

  localparam logic [POS_W-1:0] X_MAX = POS_W'(SCREEN_W - 1);

  logic             valid_q, valid_d;
  logic             dir_q, dir_d;
  logic [POS_W-1:0] x_q, x_d;
  logic [POS_W-1:0] y_q, y_d;
  logic             retire;

  // Edge retire keeps x from ever stepping past 0 or X_MAX.
  assign retire = valid_q & (hit_i |
                  ((dir_q == DIR_LEFT)  && (x_q == '0)) |
                  ((dir_q == DIR_RIGHT) && (x_q == X_MAX)));

  always_comb begin
    valid_d = valid_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    if (spawn_i) begin
      valid_d = 1'b1;
      dir_d   = spawn_dir_i;
      x_d     = spawn_x_i;
      y_d     = spawn_y_i;
    end else if (retire) begin
      valid_d = 1'b0;
    end else if (valid_q && tick_i) begin
      x_d = (dir_q == DIR_RIGHT) ? x_q + 1'b1 : x_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      dir_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      valid_q <= valid_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign dir_o   = dir_q;

endmodule

// File: rtl/bullet_scheduler.sv
// Bullet pool: shoot edge detect, cooldown, lowest-free allocation, tick.
// Ports: shoot/direction/pos_x/pos_y/hit_wall in; per-slot state out.
module bullet_scheduler #(
  parameter int N_BULLETS  = 4,
  parameter int BULLET_INV = 50,
  parameter int COOLDOWN   = 2000,
  parameter int SCREEN_W   = bullet_scheduler_pkg::SCREEN_W,
  parameter int SPAWN_DX   = 12,
  parameter int SPAWN_DY   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shoot,
  input  logic                    direction,
  input  logic [9:0]              pos_x,
  input  logic [9:0]              pos_y,
  input  logic [N_BULLETS-1:0]    hit_wall,
  output logic [N_BULLETS-1:0]    bullet_valid,
  output logic [10*N_BULLETS-1:0] bullet_x,
  output logic [10*N_BULLETS-1:0] bullet_y,
  output logic [N_BULLETS-1:0]    bullet_dir,
  output logic                    fire_pulse,
  output logic [3:0]              active_count
);
  import bullet_scheduler_pkg::*;

  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int TW = (BULLET_INV > 1) ? $clog2(BULLET_INV) : 1;
  localparam logic [POS_W:0]   X_MAX_W = (POS_W+1)'(SCREEN_W - 1);
  localparam logic [POS_W:0]   DX_W    = (POS_W+1)'(SPAWN_DX);
  localparam logic [POS_W-1:0] DX      = POS_W'(SPAWN_DX);
  localparam logic [POS_W-1:0] DY      = POS_W'(SPAWN_DY);

  logic          shoot_q;
  logic [CW-1:0] cool_q;
  logic [TW-1:0] tick_q;
  logic          fire_q;

  logic                 fire_req;
  logic                 accept;
  logic                 tick;
  logic [N_BULLETS-1:0] free_sel;
  logic [N_BULLETS-1:0] spawn;
  logic [POS_W:0]       sum_r;
  logic [POS_W-1:0]     spawn_x;
  logic [POS_W-1:0]     spawn_y;

  assign fire_req = shoot & ~shoot_q;
  assign accept   = fire_req & (cool_q == '0) & ~(&bullet_valid);
  assign tick     = (tick_q == TW'(BULLET_INV - 1));
  assign spawn    = accept ? free_sel : '0;

  // Lowest-index free slot as a one-hot vector.
  always_comb begin
    logic found;
    found    = 1'b0;
    free_sel = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (!bullet_valid[i] && !found) begin
        free_sel[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Muzzle position, clamped to the screen.
  always_comb begin
    sum_r   = {1'b0, pos_x} + DX_W;
    spawn_x = '0;
    if (direction == DIR_RIGHT) begin
      spawn_x = (sum_r > X_MAX_W) ? X_MAX_W[POS_W-1:0]
                                  : sum_r[POS_W-1:0];
    end else begin
      spawn_x = (pos_x < DX) ? '0 : pos_x - DX;
    end
    spawn_y = (pos_y < DY) ? '0 : pos_y - DY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shoot_q <= 1'b1;
      cool_q  <= '0;
      tick_q  <= '0;
      fire_q  <= 1'b0;
    end else begin
      shoot_q <= shoot;
      fire_q  <= accept;
      tick_q  <= tick ? '0 : tick_q + 1'b1;
      if (accept) begin
        cool_q <= CW'(COOLDOWN);
      end else if (cool_q != '0) begin
        cool_q <= cool_q - 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_BULLETS; g++) begin : g_slot
    bullet_slot #(
      .SCREEN_W (SCREEN_W)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .spawn_i     (spawn[g]),
      .spawn_x_i   (spawn_x),
      .spawn_y_i   (spawn_y),
      .spawn_dir_i (direction),
      .tick_i      (tick),
      .hit_i       (hit_wall[g]),
      .valid_o     (bullet_valid[g]),
      .x_o         (bullet_x[10*g +: 10]),
      .y_o         (bullet_y[10*g +: 10]),
      .dir_o       (bullet_dir[g])
    );
  end

  always_comb begin
    active_count = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      active_count = active_count + {3'b000, bullet_valid[i]};
    end
  end

  assign fire_pulse = fire_q;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Testbench for bullet_scheduler: directed scenarios plus random traffic
// checked each cycle against a slot-array model of the bullet rules.
module tb_bullet_scheduler;

  localparam int N   = 4;
  localparam int INV = 4;
  localparam int CD  = 10;
  localparam int SW  = 800;
  localparam int DX  = 12;
  localparam int DY  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          shoot = 1'b0;
  logic          direction = 1'b0;
  logic [9:0]    pos_x = '0;
  logic [9:0]    pos_y = '0;
  logic [N-1:0]  hit_wall = '0;
  logic [N-1:0]  bullet_valid;
  logic [10*N-1:0] bullet_x;
  logic [10*N-1:0] bullet_y;
  logic [N-1:0]  bullet_dir;
  logic          fire_pulse;
  logic [3:0]    active_count;

  int checks = 0;
  int errors = 0;
  int fires  = 0;

  int m_v[N];
  int m_x[N];
  int m_y[N];
  int m_d[N];
  int m_cd, m_tc, m_prev, m_fire;

  bullet_scheduler #(
    .N_BULLETS  (N),
    .BULLET_INV (INV),
    .COOLDOWN   (CD),
    .SCREEN_W   (SW),
    .SPAWN_DX   (DX),
    .SPAWN_DY   (DY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .shoot        (shoot),
    .direction    (direction),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .hit_wall     (hit_wall),
    .bullet_valid (bullet_valid),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .bullet_dir   (bullet_dir),
    .fire_pulse   (fire_pulse),
    .active_count (active_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; m_d[i] = 0;
    end
    m_cd = 0; m_tc = 0; m_prev = 1; m_fire = 0;
  endtask

  task automatic model_step();
    int free, live, req, acc, tk, ret;
    if (rst) begin
      model_reset();
      return;
    end
    free = -1;
    live = 0;
    for (int i = 0; i < N; i++) begin
      if (m_v[i] != 0) live++;
      else if (free < 0) free = i;
    end
    req = (shoot && m_prev == 0) ? 1 : 0;
    acc = (req != 0 && m_cd == 0 && free >= 0) ? 1 : 0;
    tk  = (m_tc == INV - 1) ? 1 : 0;
    for (int i = 0; i < N; i++) begin
      if (m_v[i] != 0) begin
        ret = (hit_wall[i] ||
               (m_d[i] == 0 && m_x[i] == 0) ||
               (m_d[i] == 1 && m_x[i] == SW - 1)) ? 1 : 0;
        if (ret != 0) m_v[i] = 0;
        else if (tk != 0) m_x[i] += (m_d[i] != 0) ? 1 : -1;
      end
    end
    if (acc != 0) begin
      m_v[free] = 1;
      m_d[free] = int'(direction);
      if (direction) begin
        m_x[free] = int'(pos_x) + DX;
        if (m_x[free] > SW - 1) m_x[free] = SW - 1;
      end else begin
        m_x[free] = int'(pos_x) - DX;
        if (m_x[free] < 0) m_x[free] = 0;
      end
      m_y[free] = int'(pos_y) - DY;
      if (m_y[free] < 0) m_y[free] = 0;
    end
    m_cd   = (acc != 0) ? CD : ((m_cd > 0) ? m_cd - 1 : 0);
    m_tc   = (tk != 0) ? 0 : m_tc + 1;
    m_fire = acc;
    m_prev = int'(shoot);
  endtask

  task automatic compare_all();
    int vexp, cnt;
    vexp = 0;
    cnt  = 0;
    for (int i = 0; i < N; i++) begin
      if (m_v[i] != 0) begin
        vexp |= (1 << i);
        cnt++;
      end
    end
    check("valid", int'(bullet_valid), vexp);
    check("fire", int'(fire_pulse), m_fire);
    check("count", int'(active_count), cnt);
    for (int i = 0; i < N; i++) begin
      check($sformatf("x%0d", i), int'(bullet_x[10*i +: 10]), m_x[i]);
      check($sformatf("y%0d", i), int'(bullet_y[10*i +: 10]), m_y[i]);
      check($sformatf("dir%0d", i), int'(bullet_dir[i]), m_d[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    if (fire_pulse) fires++;
    compare_all();
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic press();
    shoot = 1'b0;
    step();
    shoot = 1'b1;
    step();
  endtask

  initial begin
    model_reset();
    // Key held through reset must not fire.
    rst = 1'b1; shoot = 1'b1;
    cyc(3);
    rst = 1'b0;
    fires = 0;
    cyc(3);
    check("held_reset_fires", fires, 0);

    // First spawn at the right-facing muzzle.
    direction = 1'b1; pos_x = 10'd200; pos_y = 10'd556;
    press();
    check("spawn_fire", int'(fire_pulse), 1);
    check("spawn_valid", int'(bullet_valid), 1);
    check("spawn_x", int'(bullet_x[9:0]), 212);
    check("spawn_y", int'(bullet_y[9:0]), 548);
    check("spawn_dir", int'(bullet_dir[0]), 1);

    // Held key gives one spawn only.
    fires = 0;
    cyc(50);
    check("held_fires", fires, 0);
    press();
    check("slot1_alloc", int'(bullet_valid), 4'b0011);
    shoot = 1'b0;
    cyc(2);
    shoot = 1'b1;
    step();
    check("cool_drop", int'(fire_pulse), 0);
    shoot = 1'b0;
    cyc(CD);
    press();
    press();
    shoot = 1'b0;
    cyc(CD);
    press();
    check("full_valid", int'(bullet_valid), 4'b1111);
    check("full_count", int'(active_count), 4);
    shoot = 1'b0;
    cyc(CD);
    press();
    check("full_drop", int'(fire_pulse), 0);
    check("full_hold", int'(bullet_valid), 4'b1111);

    // Retire slot1 while pressing in the same cycle.
    shoot = 1'b0;
    cyc(CD);
    shoot = 1'b1; hit_wall = 4'b0010;
    step();
    check("hit_clear", int'(bullet_valid), 4'b1101);
    check("hit_drop", int'(fire_pulse), 0);
    hit_wall = '0;
    press();
    check("refill_slot1", int'(bullet_valid), 4'b1111);

    // Left-facing spawn near the left edge.
    shoot = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    direction = 1'b0; pos_x = 10'd15; pos_y = 10'd100;
    press();
    check("left_x", int'(bullet_x[9:0]), 3);
    for (int k = 0; k < 30; k++) begin
      step();
      check("no_wrap", int'(bullet_x[9:0] == 10'd1023), 0);
    end
    check("left_retired", int'(bullet_valid[0]), 0);

    // Reset mid-flight with cooldown active.
    direction = 1'b1; pos_x = 10'd300;
    press();
    shoot = 1'b0;
    cyc(CD);
    press();
    shoot = 1'b0;
    cyc(CD);
    press();
    rst = 1'b1; shoot = 1'b0;
    step();
    check("rst_valid", int'(bullet_valid), 0);
    check("rst_x", int'(bullet_x), 0);
    check("rst_count", int'(active_count), 0);
    rst = 1'b0;
    press();
    check("post_rst_fire", int'(fire_pulse), 1);
    check("post_rst_slot0", int'(bullet_valid), 1);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      shoot     = ($urandom_range(0, 2) == 0);
      direction = 1'($urandom_range(0, 1));
      pos_x     = 10'($urandom_range(0, 1023));
      pos_y     = 10'($urandom_range(0, 1023));
      for (int i = 0; i < N; i++)
        hit_wall[i] = ($urandom_range(0, 40) == 0);
      rst = ($urandom_range(0, 400) == 0);
      step();
    end
    rst = 1'b0; hit_wall = '0; shoot = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_scheduler.md
Name: bullet_scheduler

Overview:
Owns a fixed pool of bullet slots for the player's shoot action. It edge-detects the shoot key, enforces a fire cooldown and allocates the lowest free slot. It spawns each bullet at the player's muzzle, steps all live bullets on a shared speed tick, and retires them on wall hit or screen edge. It sits beside the player state-update block, consuming its direction/pos_x/pos_y, and feeds bullet positions to the renderer and the collision checker.

Parameters:
N_BULLETS, 4, number of bullet slots (1..8)
BULLET_INV, 50, clk cycles per 1-pixel bullet step
COOLDOWN, 2000, clk cycles after a spawn during which fire requests are dropped
SCREEN_W, 800, horizontal screen size in pixels; valid x is 0..SCREEN_W-1
SPAWN_DX, 12, horizontal muzzle offset from pos_x
SPAWN_DY, 8, vertical muzzle offset above pos_y

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
shoot  in  1  raw shoot key level
direction  in  1  player facing: 0 left, 1 right
pos_x  in  10  player x
pos_y  in  10  player y
hit_wall  in  N_BULLETS  per-slot collision flag from the external checker, aligned to current bullet_x/y
bullet_valid  out  N_BULLETS  slot i live
bullet_x  out  10*N_BULLETS  packed x, slot i at [10*i +: 10]
bullet_y  out  10*N_BULLETS  packed y
bullet_dir  out  N_BULLETS  slot travel direction, latched at spawn
fire_pulse  out  1  one-cycle high in the cycle a spawn is committed
active_count  out  4  popcount of bullet_valid

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values: bullet_valid=0, bullet_x=0, bullet_y=0, bullet_dir=0, fire_pulse=0, active_count=0, cooldown counter=0, tick counter=0.
- The shoot history register resets to 1, so a key held through reset does not fire.
- Fire request: shoot=1 and shoot_prev=0 in the same cycle. A held key yields exactly one request.
- Request dropped silently, fire_pulse=0, if cooldown counter != 0 or all slots are valid. Dropped requests are never queued.
- Accepted request in cycle t:
  - The lowest-index slot with valid=0 as sampled at t is chosen.
  - At t+1 that slot has valid=1 and dir=direction. x = pos_x+SPAWN_DX (clamped to SCREEN_W-1) when direction=1, else pos_x-SPAWN_DX (clamped to 0). y = pos_y-SPAWN_DY (clamped to 0).
  - fire_pulse is high during t+1 only. The cooldown counter loads COOLDOWN at t+1.
- Cooldown: decrements by 1 each cycle while nonzero. A request is accepted only when the count is 0.
- Move tick: a free-running counter of 0..BULLET_INV-1. tick=1 when it equals BULLET_INV-1, then it wraps to 0. On tick, every valid bullet with no retire condition moves x by +1 (dir=1) or -1 (dir=0). y is constant.
- Retire condition for valid slot i, any cycle: hit_wall[i]=1, OR (dir=0 and x==0), OR (dir=1 and x==SCREEN_W-1). valid clears next cycle. x/y hold their last values.
- Priority per slot: retire > move. A retiring slot never steps, so x never wraps past 0 or 1023.
- A slot retiring at t is not allocatable until t+1, because allocation samples valid at t. A fire and a retire on different slots in the same cycle both take effect.
- A newly spawned slot does not move in its spawn cycle, even if tick=1.
- hit_wall bits for invalid slots are ignored.
- Reset asserted mid-flight clears all slots and counters in the next cycle, regardless of tick, fire or retire.
- active_count is combinational from bullet_valid.

Decomposition:
- Shared game package: POS_W=10, SCREEN_W, direction encoding constants (DIR_LEFT=0, DIR_RIGHT=1).
- Sub-module bullet_slot: one instance per slot, holding valid/x/y/dir with spawn, tick and retire inputs and the retire>move priority.
- The parent holds the edge detect, cooldown, tick counter and lowest-free priority encoder.

Test Plan:
- Bench parameters: N_BULLETS=4, BULLET_INV=4, COOLDOWN=10, SCREEN_W=800, SPAWN_DX=12, SPAWN_DY=8.
- Reset with shoot held high; release rst -> no fire_pulse. Release then press shoot -> one fire_pulse; slot0 valid, x=212, y=548, dir=1 for pos=(200,556), direction=1.
- Hold shoot 50 cycles -> exactly one spawn. Re-press 3 cycles after a spawn -> dropped. Re-press once the cooldown has expired -> slot1 allocated.
- Four spaced presses -> slots 0..3 valid, active_count=4. A fifth press -> no fire_pulse and bullet_valid=4'b1111 unchanged.
- Slot1 hit_wall=1 for one cycle -> slot1 valid=0 next cycle. A press in that same cycle is dropped. A press in the following cycle (cooldown expired) refills slot1, not slot3.
- direction=0, pos_x=15 -> spawn x=3. After 3 ticks (12 cycles) x=0, then valid clears. x never reads 1023.
- rst pulsed with 3 bullets live and the cooldown active -> all outputs return to reset values next cycle. An immediate press after release (shoot_prev low) fires into slot0.
